timer_array: RTL and testbench
==============================

# timer_array

Parametrised bank of cascadable up-counting timers for the GBA MMIO timer subsystem, generalising the fixed four-channel 16-bit timer block. Each channel has a reload register, a control register (prescaler select, cascade, IRQ enable, start), a per-channel prescaler and an overflow/IRQ pulse output. Channel i may count overflows of channel i-1 in the same clock edge. The block sits between the MMIO register decode, which supplies write strobes, and the interrupt controller and MMIO read mux, which consume `irq` and `count`.

## Interface
- `NUM_CH`, default 4: number of timer channels, 1..8.
- `CNT_W`, default 16: counter and reload width, 8..32.
- `clock_16` input 1: the only clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low; all state cleared while low.
- `wr_sel` input $clog2(NUM_CH) (min 1): channel addressed by this cycle's writes.
- `wr_reload_en` input 1: write `wr_reload` into the reload register of `wr_sel`.
- `wr_reload` input CNT_W: reload data.
- `wr_ctrl_en` input 1: write `wr_ctrl` into the control register of `wr_sel`.
- `wr_ctrl` input 8: bits[1:0] prescale (0:/1, 1:/64, 2:/256, 3:/1024), bit2 cascade, bit6 irq_en, bit7 start; other bits are stored and read back, with no effect.
- `count` output NUM_CH*CNT_W: live counter values; channel i at [i*CNT_W +: CNT_W].
- `ctrl` output NUM_CH*8: control registers, for read-back.
- `overflow` output NUM_CH: one-cycle registered pulse per channel overflow.
- `irq` output NUM_CH: `overflow[i]` gated by that channel's irq_en as of the overflow edge.

## Operation
- Per-channel state:
  - `cnt`, CNT_W bits.
  - `reload`, CNT_W bits.
  - `ctrl`, 8 bits.
  - `pre`, a 10-bit prescale counter.
- Reset values: all `cnt`, `reload`, `ctrl` and `pre` are 0; `overflow` and `irq` are 0.
- Start edge: a ctrl write to channel i with start=1 while stored start=0 loads `cnt` with reload, clears `pre`, and sets the channel running.
  - If `wr_reload_en` targets the same channel in the same cycle, the newly written reload value is loaded.
- Stop: a ctrl write with start=0 freezes `cnt` and `pre`. The values remain readable.
- Ctrl write with start=1 while already running: updates prescale, cascade and irq_en. `cnt` and `pre` are not reset.
- Tick for channel i while running:
  - Cascade=0, or i=0: tick when `pre` equals divisor-1. `pre` then wraps to 0; otherwise `pre` increments. Divisor /1 ticks every cycle.
  - Cascade=1 with i>0: tick equals the combinational overflow condition of channel i-1 in the same cycle. `pre` is unused and holds. Chains ripple through all channels within one cycle.
  - Cascade bit on channel 0 is stored but ignored.
- On a tick with `cnt` below the all-ones value: `cnt` increments by 1.
- On a tick with `cnt` at the all-ones value: `cnt` loads reload and the overflow condition is true.
  - If a reload write to this channel occurs in the same cycle, the new value is loaded (forwarded).
- `overflow[i]` is registered: high for exactly one cycle after the overflow edge. `irq[i]` is equal to that pulse ANDed with irq_en.
- Reload writes never change `cnt` directly; they only affect the next start or overflow.
- `wr_sel` values at or above NUM_CH: writes are ignored.

## Timing
- Start write at edge E0: `cnt`=reload after E0. With /1 prescale, `cnt`=reload+1 after E1.
- With /N prescale, the first increment lands on edge E0+N, then every N edges.
- Overflow edge Ek: `cnt`=reload after Ek. `overflow` is high during cycle Ek..Ek+1 and low afterwards unless it overflows again. With reload=all-ones and /1, `overflow` is high continuously.
- Cascaded channel increment: on the same edge Ek as the upstream overflow. Its own `overflow` is registered on that edge too, so zero added latency per stage.
- Reset assertion mid-count: all outputs go to 0 asynchronously. Counting resumes only after a new start write.
- Simultaneous start edge and upstream cascade overflow on a cascaded channel: the start load wins, and that tick is dropped.
- Stop write in the same cycle as a would-be overflow: no overflow occurs; `cnt` holds its all-ones value.

## Test plan
- Channel 0, reload=0xFFFE, ctrl=0x80 (/1, start) -> `cnt` goes 0xFFFE, then 0xFFFF, then 0xFFFE. `overflow[0]` pulses once, on the cycle after the third edge. `irq[0]` stays 0.
- Channel 0, reload=0xFFFF, ctrl=0xC1 (/64, irq_en, start) -> `cnt` holds 0xFFFF for 63 edges. On edge 64 `cnt` reloads 0xFFFF, and `overflow[0]` and `irq[0]` pulse for one cycle. This repeats every 64 cycles.
- Cascade: ch0 reload=0xFFFF /1 start, ch1 reload=0xFFFD ctrl=0x84 -> ch1 steps 0xFFFD→0xFFFE→0xFFFF→0xFFFD on successive cycles. `overflow[1]` pulses on the same cycle as the third `overflow[0]` pulse.
- Reload write to ch0 with value 0x1234, in the exact cycle ch0 overflows -> `cnt`=0x1234 after that edge. A stop write on a later cycle freezes `cnt`; a restart reloads 0x1234.
- Stop/restart: ch2 running /1 from 0x0000; stop after 10 edges -> `cnt`=0x000A and holds. A restart write reloads 0x0000.
- Reset pulled low mid-count with NUM_CH=8, CNT_W=8 -> all `count`, `ctrl`, `overflow` and `irq` are 0 immediately. No counting occurs until a new start write.

Source files
------------

// File: rtl/timer_array_if.sv
// MMIO-side bundle for timer_array: write strobes in, counters/ctrl/overflow/irq out.
// The master side is the register decode and read mux; the slave side is the timer bank.
interface timer_array_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [SEL_W-1:0]        wr_sel;
  logic                    wr_reload_en;
  logic [CNT_W-1:0]        wr_reload;
  logic                    wr_ctrl_en;
  logic [7:0]              wr_ctrl;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH*8-1:0]     ctrl;
  logic [NUM_CH-1:0]       overflow;
  logic [NUM_CH-1:0]       irq;

  modport master (
    output wr_sel, wr_reload_en, wr_reload, wr_ctrl_en, wr_ctrl,
    input  count, ctrl, overflow, irq
  );

  modport slave (
    input  wr_sel, wr_reload_en, wr_reload, wr_ctrl_en, wr_ctrl,
    output count, ctrl, overflow, irq
  );
endinterface

// File: rtl/timer_array.sv
// Bank of cascadable up-counting timers with per-channel prescaler and overflow/irq pulses.
// Overflow of channel i-1 feeds channel i combinationally so cascade chains resolve in one edge.

module timer_array_ch #(
  parameter int CNT_W = 16,
  parameter bit FIRST = 1'b0
) (
  input  logic             clock_16,
  input  logic             reset,
  input  logic             reload_we_i,
  input  logic [CNT_W-1:0] reload_wd_i,
  input  logic             ctrl_we_i,
  input  logic [7:0]       ctrl_wd_i,
  input  logic             up_ovf_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [7:0]       ctrl_o,
  output logic             ovf_c_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, reload_q, reload_d, reload_eff;
  logic [7:0]       ctrl_q, ctrl_d;
  logic [9:0]       pre_q, pre_d, div_m1;
  logic             run, start_edge, stop, casc, pre_hit, tick, ovf_c;

  always_comb begin
    run        = ctrl_q[7];
    start_edge = ctrl_we_i & ctrl_wd_i[7] & ~run;
    stop       = ctrl_we_i & ~ctrl_wd_i[7];
    reload_eff = reload_we_i ? reload_wd_i : reload_q;
    casc       = ctrl_q[2] & ~FIRST;
    case (ctrl_q[1:0])
      2'd0:    div_m1 = 10'd0;
      2'd1:    div_m1 = 10'd63;
      2'd2:    div_m1 = 10'd255;
      default: div_m1 = 10'd1023;
    endcase
    pre_hit = (pre_q == div_m1);
    // A stop write in the same cycle suppresses the tick, so all-ones holds without overflowing.
    tick    = run & ~stop & (casc ? up_ovf_i : pre_hit);
    ovf_c   = tick & (&cnt_q);

    cnt_d    = cnt_q;
    pre_d    = pre_q;
    reload_d = reload_we_i ? reload_wd_i : reload_q;
    ctrl_d   = ctrl_we_i ? ctrl_wd_i : ctrl_q;
    if (start_edge) begin
      cnt_d = reload_eff;
      pre_d = 10'd0;
    end else if (run & ~stop) begin
      if (!casc) pre_d = pre_hit ? 10'd0 : pre_q + 10'd1;
      if (tick)  cnt_d = ovf_c ? reload_eff : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_16 or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      reload_q <= '0;
      ctrl_q   <= '0;
      pre_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      ctrl_q   <= ctrl_d;
      pre_q    <= pre_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign ctrl_o  = ctrl_q;
  assign ovf_c_o = ovf_c;
endmodule

module timer_array #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input logic          clock_16,
  input logic          reset,
  timer_array_if.slave bus
);
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_w;
  logic [NUM_CH-1:0][7:0]       ctrl_w;
  logic [NUM_CH-1:0]            ovf_c, up_ovf, sel_w, ovf_q, irq_q;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Select values beyond NUM_CH-1 match no channel, so those writes fall away.
      assign sel_w[i] = (32'(bus.wr_sel) == i);
      if (i == 0) begin : g_head
        assign up_ovf[i] = 1'b0;
      end else begin : g_link
        assign up_ovf[i] = ovf_c[i-1];
      end
      timer_array_ch #(.CNT_W(CNT_W), .FIRST(i == 0)) u_ch (
        .clock_16    (clock_16),
        .reset       (reset),
        .reload_we_i (bus.wr_reload_en & sel_w[i]),
        .reload_wd_i (bus.wr_reload),
        .ctrl_we_i   (bus.wr_ctrl_en & sel_w[i]),
        .ctrl_wd_i   (bus.wr_ctrl),
        .up_ovf_i    (up_ovf[i]),
        .cnt_o       (cnt_w[i]),
        .ctrl_o      (ctrl_w[i]),
        .ovf_c_o     (ovf_c[i])
      );
    end
  endgenerate

  always_ff @(posedge clock_16 or negedge reset) begin
    if (!reset) begin
      ovf_q <= '0;
      irq_q <= '0;
    end else begin
      ovf_q <= ovf_c;
      for (int i = 0; i < NUM_CH; i++) irq_q[i] <= ovf_c[i] & ctrl_w[i][6];
    end
  end

  assign bus.count    = cnt_w;
  assign bus.ctrl     = ctrl_w;
  assign bus.overflow = ovf_q;
  assign bus.irq      = irq_q;
endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array: default 4x16 bank, an 8x8 bank for reset, a 3-channel bank for select range.
module tb_timer_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   n;

  always #5 clk = ~clk;

  timer_array_if #(.NUM_CH(4), .CNT_W(16)) ifa ();
  timer_array_if #(.NUM_CH(8), .CNT_W(8))  ifb ();
  timer_array_if #(.NUM_CH(3), .CNT_W(8))  ifc ();

  timer_array #(.NUM_CH(4), .CNT_W(16)) dut_a (.clock_16(clk), .reset(rst_n), .bus(ifa.slave));
  timer_array #(.NUM_CH(8), .CNT_W(8))  dut_b (.clock_16(clk), .reset(rst_n), .bus(ifb.slave));
  timer_array #(.NUM_CH(3), .CNT_W(8))  dut_c (.clock_16(clk), .reset(rst_n), .bus(ifc.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wra(input int sel, input bit ren, input logic [15:0] rv, input bit cen, input logic [7:0] cv);
    ifa.wr_sel = 2'(sel); ifa.wr_reload_en = ren; ifa.wr_reload = rv;
    ifa.wr_ctrl_en = cen; ifa.wr_ctrl = cv;
    step();
    ifa.wr_reload_en = 1'b0; ifa.wr_ctrl_en = 1'b0;
  endtask

  task automatic wrb(input int sel, input bit ren, input logic [7:0] rv, input bit cen, input logic [7:0] cv);
    ifb.wr_sel = 3'(sel); ifb.wr_reload_en = ren; ifb.wr_reload = rv;
    ifb.wr_ctrl_en = cen; ifb.wr_ctrl = cv;
    step();
    ifb.wr_reload_en = 1'b0; ifb.wr_ctrl_en = 1'b0;
  endtask

  initial begin
    ifa.wr_sel = '0; ifa.wr_reload_en = 0; ifa.wr_reload = '0; ifa.wr_ctrl_en = 0; ifa.wr_ctrl = '0;
    ifb.wr_sel = '0; ifb.wr_reload_en = 0; ifb.wr_reload = '0; ifb.wr_ctrl_en = 0; ifb.wr_ctrl = '0;
    ifc.wr_sel = '0; ifc.wr_reload_en = 0; ifc.wr_reload = '0; ifc.wr_ctrl_en = 0; ifc.wr_ctrl = '0;

    // reset state
    #12;
    chk("rst_count", 64'(ifa.count), 64'h0);
    chk("rst_ctrl",  64'(ifa.ctrl), 64'h0);
    chk("rst_ovf",   64'(ifa.overflow), 64'h0);
    chk("rst_irq",   64'(ifa.irq), 64'h0);
    rst_n = 1'b1;
    step();

    // ch0 reload FFFE /1: FFFE, FFFF, FFFE with one overflow, no irq
    wra(0, 1, 16'hFFFE, 0, 8'h00);
    wra(0, 0, 16'h0, 1, 8'h80);
    chk("t1_e0_cnt", 64'(ifa.count[0 +: 16]), 64'hFFFE);
    step();
    chk("t1_e1_cnt", 64'(ifa.count[0 +: 16]), 64'hFFFF);
    chk("t1_e1_ovf", 64'(ifa.overflow[0]), 64'h0);
    step();
    chk("t1_e2_cnt", 64'(ifa.count[0 +: 16]), 64'hFFFE);
    chk("t1_e2_ovf", 64'(ifa.overflow[0]), 64'h1);
    chk("t1_e2_irq", 64'(ifa.irq[0]), 64'h0);
    step();
    chk("t1_e3_ovf", 64'(ifa.overflow[0]), 64'h0);

    // ch0 reload FFFF /64 irq_en, reload and start in the same cycle
    rst_pulse();
    wra(0, 1, 16'hFFFF, 1, 8'hC1);
    chk("t2_e0_cnt", 64'(ifa.count[0 +: 16]), 64'hFFFF);
    chk("t2_ctrl",   64'(ifa.ctrl[0 +: 8]), 64'hC1);
    n = 0;
    repeat (63) begin step(); n += int'(ifa.overflow[0]); end
    chk("t2_quiet63", 64'(n), 64'h0);
    step();
    chk("t2_e64_ovf", 64'(ifa.overflow[0]), 64'h1);
    chk("t2_e64_irq", 64'(ifa.irq[0]), 64'h1);
    chk("t2_e64_cnt", 64'(ifa.count[0 +: 16]), 64'hFFFF);
    step();
    chk("t2_e65_ovf", 64'(ifa.overflow[0]), 64'h0);
    n = 0;
    repeat (62) begin step(); n += int'(ifa.overflow[0]); end
    chk("t2_quiet2", 64'(n), 64'h0);
    step();
    chk("t2_e128_irq", 64'(ifa.irq[0]), 64'h1);

    // cascade: ch1 counts ch0 overflows
    rst_pulse();
    wra(1, 1, 16'hFFFD, 0, 8'h00);
    wra(1, 0, 16'h0, 1, 8'h84);
    wra(0, 1, 16'hFFFF, 1, 8'h80);
    chk("t3_s_cnt1", 64'(ifa.count[16 +: 16]), 64'hFFFD);
    step();
    chk("t3_1_cnt1", 64'(ifa.count[16 +: 16]), 64'hFFFE);
    chk("t3_1_ovf",  64'(ifa.overflow[1:0]), 64'h1);
    step();
    chk("t3_2_cnt1", 64'(ifa.count[16 +: 16]), 64'hFFFF);
    chk("t3_2_ovf",  64'(ifa.overflow[1:0]), 64'h1);
    step();
    chk("t3_3_cnt1", 64'(ifa.count[16 +: 16]), 64'hFFFD);
    chk("t3_3_ovf",  64'(ifa.overflow[1:0]), 64'h3);
    step();
    chk("t3_4_ovf",  64'(ifa.overflow[1:0]), 64'h1);

    // reload write lands on the overflow edge and is forwarded
    rst_pulse();
    wra(0, 1, 16'hFFFE, 1, 8'h80);
    step();
    chk("t4_pre_cnt", 64'(ifa.count[0 +: 16]), 64'hFFFF);
    wra(0, 1, 16'h1234, 0, 8'h00);
    chk("t4_fwd_cnt", 64'(ifa.count[0 +: 16]), 64'h1234);
    chk("t4_fwd_ovf", 64'(ifa.overflow[0]), 64'h1);
    step();
    wra(0, 0, 16'h0, 1, 8'h00);
    chk("t4_stop_cnt", 64'(ifa.count[0 +: 16]), 64'h1235);
    step();
    chk("t4_hold_cnt", 64'(ifa.count[0 +: 16]), 64'h1235);
    wra(0, 0, 16'h0, 1, 8'h80);
    chk("t4_restart", 64'(ifa.count[0 +: 16]), 64'h1234);

    // ch2 stop/restart from zero
    rst_pulse();
    wra(2, 0, 16'h0, 1, 8'h80);
    repeat (10) step();
    chk("t5_ten", 64'(ifa.count[32 +: 16]), 64'h000A);
    wra(2, 0, 16'h0, 1, 8'h00);
    step();
    chk("t5_hold", 64'(ifa.count[32 +: 16]), 64'h000A);
    wra(2, 0, 16'h0, 1, 8'h80);
    chk("t5_restart", 64'(ifa.count[32 +: 16]), 64'h0000);
    step();
    chk("t5_run", 64'(ifa.count[32 +: 16]), 64'h0001);

    // stop in the same cycle as a would-be overflow
    wra(3, 1, 16'hFFFF, 1, 8'h80);
    wra(3, 0, 16'h0, 1, 8'h00);
    chk("t6_stop_cnt", 64'(ifa.count[48 +: 16]), 64'hFFFF);
    chk("t6_stop_ovf", 64'(ifa.overflow[3]), 64'h0);
    step();
    chk("t6_hold_ovf", 64'(ifa.overflow[3]), 64'h0);

    // 8x8 bank: continuous overflow at reload=FF, then async reset mid-count
    rst_pulse();
    wrb(7, 1, 8'hFF, 1, 8'hC0);
    wrb(0, 1, 8'h10, 1, 8'h80);
    chk("t7_cont_ovf", 64'(ifb.overflow[7]), 64'h1);
    step();
    chk("t7_cont_irq", 64'(ifb.irq[7]), 64'h1);
    chk("t7_cnt0", 64'(ifb.count[0 +: 8]), 64'h11);
    rst_n = 1'b0;
    #2;
    chk("t7_rst_count", 64'(ifb.count), 64'h0);
    chk("t7_rst_ctrl",  64'(ifb.ctrl), 64'h0);
    chk("t7_rst_ovf",   64'(ifb.overflow), 64'h0);
    chk("t7_rst_irq",   64'(ifb.irq), 64'h0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("t7_idle", 64'(ifb.count), 64'h0);
    wrb(7, 0, 8'h0, 1, 8'h80);
    step();
    chk("t7_resume", 64'(ifb.count[56 +: 8]), 64'h01);

    // 3-channel bank: wr_sel=3 is out of range and ignored
    ifc.wr_sel = 2'd3; ifc.wr_reload_en = 1; ifc.wr_reload = 8'h55; ifc.wr_ctrl_en = 1; ifc.wr_ctrl = 8'h80;
    step();
    ifc.wr_reload_en = 0; ifc.wr_ctrl_en = 0;
    step();
    chk("t8_oor_ctrl",  64'(ifc.ctrl), 64'h0);
    chk("t8_oor_count", 64'(ifc.count), 64'h0);
    ifc.wr_sel = 2'd2; ifc.wr_reload_en = 1; ifc.wr_reload = 8'h05; ifc.wr_ctrl_en = 1; ifc.wr_ctrl = 8'h80;
    step();
    ifc.wr_reload_en = 0; ifc.wr_ctrl_en = 0;
    chk("t8_ch2_cnt", 64'(ifc.count[16 +: 8]), 64'h05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
